// File: rtl/toy_alu_issue_queue_pkg.sv
// Shared types for the ALU issue queue: the micro-op payload, the queue entry and the sizing constants.
// No logic here. Flow control is defined by the modules that use these types.
package toy_alu_issue_queue_pkg;

    localparam int REG_WIDTH        = 32;
    localparam int PHY_REG_ID_WIDTH = 6;
    localparam int ALU_IQ_DEPTH     = 8;
    localparam int WB_PORTS         = 2;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADDI = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7
    } alu_op_t;

    typedef struct packed {
        alu_op_t                     op;
        logic [PHY_REG_ID_WIDTH-1:0] rd_idx;
        logic [REG_WIDTH-1:0]        imm;
        logic [REG_WIDTH-1:0]        reg_rs1_val;
        logic [REG_WIDTH-1:0]        reg_rs2_val;
    } eu_pkg;

    typedef struct packed {
        logic                        vld;
        eu_pkg                       pld;
        logic [PHY_REG_ID_WIDTH-1:0] rs1_idx;
        logic [PHY_REG_ID_WIDTH-1:0] rs2_idx;
        logic                        rs1_rdy;
        logic                        rs2_rdy;
    } iq_entry_t;

    function automatic logic entry_ready(iq_entry_t e);
        return e.vld && e.rs1_rdy && e.rs2_rdy;
    endfunction

endpackage

// File: rtl/toy_alu_issue_queue_if.sv
// Dispatch, writeback broadcast, flush and ALU issue signals of the issue queue.
// master = dispatch/ALU side, slave = the queue itself.
interface toy_alu_issue_queue_if
    import toy_alu_issue_queue_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WB_PORTS = 2
);
    logic                                       enq_vld;
    logic                                       enq_rdy;
    eu_pkg                                      enq_pld;
    logic [PHY_REG_ID_WIDTH-1:0]                enq_rs1_idx;
    logic [PHY_REG_ID_WIDTH-1:0]                enq_rs2_idx;
    logic                                       enq_rs1_rdy;
    logic                                       enq_rs2_rdy;
    logic [WB_PORTS-1:0]                        wb_vld;
    logic [WB_PORTS-1:0][PHY_REG_ID_WIDTH-1:0]  wb_idx;
    logic [WB_PORTS-1:0][REG_WIDTH-1:0]         wb_data;
    logic                                       flush;
    logic                                       issue_vld;
    logic                                       issue_rdy;
    eu_pkg                                      issue_pld;
    logic [$clog2(DEPTH+1)-1:0]                 count;

    modport master (
        output enq_vld, enq_pld, enq_rs1_idx, enq_rs2_idx, enq_rs1_rdy, enq_rs2_rdy,
        output wb_vld, wb_idx, wb_data, flush, issue_rdy,
        input  enq_rdy, issue_vld, issue_pld, count
    );

    modport slave (
        input  enq_vld, enq_pld, enq_rs1_idx, enq_rs2_idx, enq_rs1_rdy, enq_rs2_rdy,
        input  wb_vld, wb_idx, wb_data, flush, issue_rdy,
        output enq_rdy, issue_vld, issue_pld, count
    );
endinterface

// File: rtl/toy_alu_iq_entry.sv
// One issue-queue slot: picks hold / shift-down / enqueue, then applies writeback wakeup to the result.
// Latency: next state registered in one cycle. No backpressure of its own; the top decides enq/shift.
module toy_alu_iq_entry
    import toy_alu_issue_queue_pkg::*;
#(
    parameter int WB_PORTS = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      flush,
    input  logic                                      enq_en,
    input  iq_entry_t                                 enq_entry,
    input  logic                                      shift_en,
    input  iq_entry_t                                 shift_entry,
    input  logic [WB_PORTS-1:0]                       wb_vld,
    input  logic [WB_PORTS-1:0][PHY_REG_ID_WIDTH-1:0] wb_idx,
    input  logic [WB_PORTS-1:0][REG_WIDTH-1:0]        wb_data,
    output iq_entry_t                                 cur,
    output logic                                      rdy
);

    iq_entry_t base;
    iq_entry_t nxt;

    always_comb begin
        base = cur;
        if (enq_en) begin
            base = enq_entry;
        end else if (shift_en) begin
            base = shift_entry;
        end

        // Wakeup is applied after the mux so enqueue capture and shifted entries see this cycle's broadcast.
        // Walking ports high to low lets the lowest matching port win.
        nxt = base;
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (base.vld && !base.rs1_rdy && wb_vld[p] && (wb_idx[p] == base.rs1_idx)) begin
                nxt.rs1_rdy         = 1'b1;
                nxt.pld.reg_rs1_val = wb_data[p];
            end
            if (base.vld && !base.rs2_rdy && wb_vld[p] && (wb_idx[p] == base.rs2_idx)) begin
                nxt.rs2_rdy         = 1'b1;
                nxt.pld.reg_rs2_val = wb_data[p];
            end
        end

        if (flush) begin
            nxt.vld = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= '0;
        end else begin
            cur <= nxt;
        end
    end

    assign rdy = entry_ready(cur);

endmodule

// File: rtl/toy_alu_issue_queue.sv
// Collapsing data-capture issue queue feeding the ALU; oldest ready entry is offered each cycle.
// Latency: enqueue/wakeup to issue_vld is one cycle. enq_rdy drops at full, with no credit for same-cycle issue.
module toy_alu_issue_queue
    import toy_alu_issue_queue_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WB_PORTS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    toy_alu_issue_queue_if.slave  iq
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH);

    iq_entry_t        ent       [DEPTH];
    iq_entry_t        shift_src [DEPTH];
    iq_entry_t        enq_entry;
    logic [DEPTH-1:0] rdy_vec;
    logic [DEPTH-1:0] enq_en;
    logic [DEPTH-1:0] shift_en;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    enq_slot;
    logic [SW-1:0]    sel;
    logic             enq_fire;
    logic             issue_fire;

    // Priority select: iterate from the top so the lowest-index ready slot is what remains.
    always_comb begin
        iq.issue_vld = |rdy_vec;
        iq.issue_pld = '0;
        sel          = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rdy_vec[i]) begin
                sel          = SW'(i);
                iq.issue_pld = ent[i].pld;
            end
        end
    end

    assign iq.enq_rdy = (cnt < CW'(DEPTH));
    assign enq_fire   = iq.enq_vld && iq.enq_rdy && !iq.flush;
    assign issue_fire = iq.issue_vld && iq.issue_rdy;
    assign enq_slot   = issue_fire ? (cnt - CW'(1)) : cnt;

    always_comb begin
        enq_entry         = '0;
        enq_entry.vld     = 1'b1;
        enq_entry.pld     = iq.enq_pld;
        enq_entry.rs1_idx = iq.enq_rs1_idx;
        enq_entry.rs2_idx = iq.enq_rs2_idx;
        enq_entry.rs1_rdy = iq.enq_rs1_rdy;
        enq_entry.rs2_rdy = iq.enq_rs2_rdy;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign enq_en[g]   = enq_fire && (enq_slot == CW'(g));
        assign shift_en[g] = issue_fire && (SW'(g) >= sel);

        if (g == DEPTH - 1) begin : g_top
            assign shift_src[g] = '0;
        end else begin : g_mid
            assign shift_src[g] = ent[g+1];
        end

        toy_alu_iq_entry #(
            .WB_PORTS (WB_PORTS)
        ) u_entry (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush       (iq.flush),
            .enq_en      (enq_en[g]),
            .enq_entry   (enq_entry),
            .shift_en    (shift_en[g]),
            .shift_entry (shift_src[g]),
            .wb_vld      (iq.wb_vld),
            .wb_idx      (iq.wb_idx),
            .wb_data     (iq.wb_data),
            .cur         (ent[g]),
            .rdy         (rdy_vec[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (iq.flush) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(enq_fire) - CW'(issue_fire);
        end
    end

    assign iq.count = cnt;

endmodule

// File: tb/tb_toy_alu_issue_queue.sv
// Bench for the ALU issue queue: directed scenarios plus random traffic against an age-ordered queue model.
module tb_toy_alu_issue_queue;
    import toy_alu_issue_queue_pkg::*;

    localparam int D  = ALU_IQ_DEPTH;
    localparam int NP = toy_alu_issue_queue_pkg::WB_PORTS;

    typedef struct {
        eu_pkg                       pld;
        logic [PHY_REG_ID_WIDTH-1:0] t1;
        logic [PHY_REG_ID_WIDTH-1:0] t2;
        logic                        r1;
        logic                        r2;
    } m_ent_t;

    logic   clk = 1'b0;
    logic   rst_n;
    int     n_chk  = 0;
    int     n_pass = 0;
    m_ent_t mq[$];
    eu_pkg  got_q[$];

    always #5 clk = ~clk;

    toy_alu_issue_queue_if #(.DEPTH(D), .WB_PORTS(NP)) qif ();

    toy_alu_issue_queue #(.DEPTH(D), .WB_PORTS(NP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .iq    (qif.slave)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic m_ent_t wake(input m_ent_t e);
        m_ent_t r = e;
        for (int p = 0; p < NP; p++) begin
            if (!r.r1 && qif.wb_vld[p] && qif.wb_idx[p] == r.t1) begin
                r.r1 = 1'b1;
                r.pld.reg_rs1_val = qif.wb_data[p];
            end
            if (!r.r2 && qif.wb_vld[p] && qif.wb_idx[p] == r.t2) begin
                r.r2 = 1'b1;
                r.pld.reg_rs2_val = qif.wb_data[p];
            end
        end
        return r;
    endfunction

    task automatic idle();
        qif.enq_vld     = 1'b0;
        qif.enq_pld     = '0;
        qif.enq_rs1_idx = '0;
        qif.enq_rs2_idx = '0;
        qif.enq_rs1_rdy = 1'b0;
        qif.enq_rs2_rdy = 1'b0;
        qif.wb_vld      = '0;
        qif.wb_idx      = '0;
        qif.wb_data     = '0;
        qif.flush       = 1'b0;
        qif.issue_rdy   = 1'b0;
    endtask

    task automatic set_enq(input logic [5:0] rd, input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                           input logic [5:0] t2, input logic r2, input logic [31:0] v2);
        qif.enq_vld             = 1'b1;
        qif.enq_pld.op          = ALU_ADD;
        qif.enq_pld.rd_idx      = rd;
        qif.enq_pld.imm         = 32'h0;
        qif.enq_pld.reg_rs1_val = v1;
        qif.enq_pld.reg_rs2_val = v2;
        qif.enq_rs1_idx         = t1;
        qif.enq_rs2_idx         = t2;
        qif.enq_rs1_rdy         = r1;
        qif.enq_rs2_rdy         = r2;
    endtask

    // Compare outputs against the model, advance the model by this cycle's inputs, then clock.
    task automatic cycle();
        int     sel = -1;
        eu_pkg  exp_pld = '0;
        m_ent_t e;
        logic   accept;
        foreach (mq[i]) if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
        if (sel >= 0) exp_pld = mq[sel].pld;
        chk("issue_vld", qif.issue_vld, sel >= 0);
        chk("issue_pld", qif.issue_pld, exp_pld);
        chk("enq_rdy", qif.enq_rdy, mq.size() < D);
        chk("count", qif.count, mq.size());
        if (qif.issue_vld && qif.issue_rdy) got_q.push_back(qif.issue_pld);
        accept = qif.enq_vld && (mq.size() < D) && !qif.flush;
        if (sel >= 0 && qif.issue_rdy) mq.delete(sel);
        foreach (mq[i]) mq[i] = wake(mq[i]);
        if (accept) begin
            e.pld = qif.enq_pld;
            e.t1  = qif.enq_rs1_idx;
            e.t2  = qif.enq_rs2_idx;
            e.r1  = qif.enq_rs1_rdy;
            e.r2  = qif.enq_rs2_rdy;
            mq.push_back(wake(e));
        end
        if (qif.flush) mq.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        chk("rst_issue_vld", qif.issue_vld, 1'b0);
        chk("rst_issue_pld", qif.issue_pld, '0);
        chk("rst_enq_rdy", qif.enq_rdy, 1'b1);
        chk("rst_count", qif.count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ready at enqueue.
        set_enq(6'd1, 6'd2, 1'b1, 32'h5, 6'd3, 1'b1, 32'h0);
        qif.enq_pld.op  = ALU_ADDI;
        qif.enq_pld.imm = 32'd3;
        cycle();
        idle();
        chk("rdy_enq_vld", qif.issue_vld, 1'b1);
        chk("rdy_enq_rs1", qif.issue_pld.reg_rs1_val, 32'h5);
        qif.issue_rdy = 1'b1;
        cycle();
        idle();
        cycle();

        // Wakeup capture on port 1.
        set_enq(6'd4, 6'd2, 1'b1, 32'h11, 6'd17, 1'b0, 32'h0);
        cycle();
        idle();
        cycle();
        cycle();
        qif.wb_vld[1]  = 1'b1;
        qif.wb_idx[1]  = 6'd17;
        qif.wb_data[1] = 32'hDEAD_BEEF;
        cycle();
        idle();
        chk("wake_vld", qif.issue_vld, 1'b1);
        chk("wake_rs2", qif.issue_pld.reg_rs2_val, 32'hDEAD_BEEF);
        qif.issue_rdy = 1'b1;
        cycle();
        idle();

        // Age order: A waits on tag 9, B and C ready.
        got_q.delete();
        set_enq(6'd1, 6'd9, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);
        cycle();
        set_enq(6'd2, 6'd0, 1'b1, 32'h2, 6'd0, 1'b1, 32'h0);
        cycle();
        set_enq(6'd3, 6'd0, 1'b1, 32'h3, 6'd0, 1'b1, 32'h0);
        cycle();
        idle();
        qif.issue_rdy = 1'b1;
        cycle();
        cycle();
        qif.wb_vld[0]  = 1'b1;
        qif.wb_idx[0]  = 6'd9;
        qif.wb_data[0] = 32'h99;
        cycle();
        qif.wb_vld = '0;
        cycle();
        idle();
        chk("age_n", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("age_0", got_q[0].rd_idx, 6'd2);
            chk("age_1", got_q[1].rd_idx, 6'd3);
            chk("age_2", got_q[2].rd_idx, 6'd1);
            chk("age_2_rs1", got_q[2].reg_rs1_val, 32'h99);
        end

        // Full queue, then issue with enq_vld held.
        for (int i = 0; i < D; i++) begin
            set_enq(6'(10 + i), 6'd0, 1'b1, 32'(i), 6'd0, 1'b1, 32'h0);
            cycle();
        end
        chk("full_enq_rdy", qif.enq_rdy, 1'b0);
        set_enq(6'd30, 6'd0, 1'b1, 32'h30, 6'd0, 1'b1, 32'h0);
        qif.issue_rdy = 1'b1;
        cycle();
        qif.issue_rdy = 1'b0;
        chk("full_rise", qif.enq_rdy, 1'b1);
        cycle();
        idle();
        chk("full_count", qif.count, D);
        qif.issue_rdy = 1'b1;
        for (int i = 0; i < D; i++) cycle();
        idle();

        // Enqueue/wakeup collision, single then both ports.
        set_enq(6'd5, 6'd4, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);
        qif.wb_vld[0]  = 1'b1;
        qif.wb_idx[0]  = 6'd4;
        qif.wb_data[0] = 32'h77;
        cycle();
        idle();
        chk("coll_rs1", qif.issue_pld.reg_rs1_val, 32'h77);
        qif.issue_rdy = 1'b1;
        cycle();
        set_enq(6'd6, 6'd4, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);
        qif.wb_vld     = '1;
        qif.wb_idx[0]  = 6'd4;
        qif.wb_idx[1]  = 6'd4;
        qif.wb_data[0] = 32'h77;
        qif.wb_data[1] = 32'h88;
        cycle();
        idle();
        chk("coll2_rs1", qif.issue_pld.reg_rs1_val, 32'h77);
        qif.issue_rdy = 1'b1;
        cycle();
        idle();

        // Flush with 5 entries and a concurrent enqueue.
        for (int i = 0; i < 5; i++) begin
            set_enq(6'(20 + i), 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2);
            cycle();
        end
        set_enq(6'd40, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2);
        qif.flush = 1'b1;
        cycle();
        idle();
        chk("flush_count", qif.count, 0);
        cycle();

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            set_enq(6'(30 + i), 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2);
            cycle();
        end
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_issue_vld", qif.issue_vld, 1'b0);
        chk("arst_count", qif.count, 0);
        mq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic with a small tag space so wakeups and collisions are frequent.
        for (int c = 0; c < 1500; c++) begin
            idle();
            if ($urandom_range(0, 1) == 1) begin
                set_enq(6'($urandom_range(0, 63)), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                        $urandom, 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
                qif.enq_pld.op  = alu_op_t'($urandom_range(0, 7));
                qif.enq_pld.imm = $urandom;
            end
            for (int p = 0; p < NP; p++) begin
                qif.wb_vld[p]  = ($urandom_range(0, 2) == 0);
                qif.wb_idx[p]  = 6'($urandom_range(0, 7));
                qif.wb_data[p] = $urandom;
            end
            qif.flush     = ($urandom_range(0, 63) == 0);
            qif.issue_rdy = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/toy_alu_issue_queue.md
# toy_alu_issue_queue

Out-of-order, data-capture issue queue directly upstream of the integer ALU. It buffers dispatched ALU micro-ops (`eu_pkg`) and captures source operand values from writeback broadcasts. Each cycle it presents the oldest entry with both operands ready on the ALU's `instruction_vld` / `instruction_rdy` / `instruction_pld` handshake. A flush clears all entries.

## Interface

**Parameters**
- `DEPTH`, default 8: number of entries (≥2).
- `WB_PORTS`, default 2: number of writeback/wakeup broadcast ports.

**Ports**
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `enq_vld` in 1: dispatch valid.
- `enq_rdy` out 1: queue can accept one entry.
- `enq_pld` in `eu_pkg`: micro-op. `reg_rs1_val` / `reg_rs2_val` are meaningful only when the matching rdy bit is set.
- `enq_rs1_idx`, `enq_rs2_idx` in `PHY_REG_ID_WIDTH`: physical source tags.
- `enq_rs1_rdy`, `enq_rs2_rdy` in 1: operand value already present in `enq_pld`.
- `wb_vld` in `WB_PORTS`: writeback broadcast valid, one bit per port.
- `wb_idx` in `WB_PORTS × PHY_REG_ID_WIDTH`: physical destination tag per port.
- `wb_data` in `WB_PORTS × REG_WIDTH`: result value per port.
- `flush` in 1: pipeline flush.
- `issue_vld` out 1: drives ALU `instruction_vld`.
- `issue_rdy` in 1: from ALU `instruction_rdy`.
- `issue_pld` out `eu_pkg`: drives ALU `instruction_pld`, with captured rs1/rs2 values substituted.
- `count` out `$clog2(DEPTH+1)`: occupied entries, for dispatch and debug.

## Operation

- **Storage.** The queue is collapsing. Valid entries always occupy slots `0..count-1` in age order, with slot 0 the oldest.
- **Entry state.** Each entry holds `eu_pkg`, `rs1_idx`, `rs2_idx`, `rs1_rdy`, `rs2_rdy`.
- **Enqueue.** Enqueue fires when `enq_vld && enq_rdy && !flush`.
  - `enq_rdy = (count < DEPTH)`. No credit is given for a same-cycle issue.
  - The new entry is written at slot `count`, or at slot `count-1` if an issue fires in the same cycle.
- **Same-cycle capture at enqueue.** For each non-ready source:
  - If any `wb_vld[p]` is set with `wb_idx[p]` equal to that source's tag, the entry is written with rdy=1 and value=`wb_data[p]`.
  - If several ports match, the lowest-numbered port wins.
- **Wakeup.** Every valid entry compares each not-ready source tag against all wb ports every cycle. On a match it sets rdy and captures the data, lowest port winning. Already-ready sources are never overwritten.
- **Select.**
  - An entry is ready when `rs1_rdy && rs2_rdy`, evaluated from registered state only.
  - `issue_vld` is the OR of ready over valid entries.
  - `issue_pld` is taken from the lowest-index ready entry. When `issue_vld` is 0, `issue_pld` is all-zero.
- **Issue.**
  - Issue fires when `issue_vld && issue_rdy`.
  - The selected entry is removed, and every entry above it shifts down one slot. Shifted entries still apply that cycle's wakeup.
  - While `issue_rdy` is low, the selection may move to an older entry that has become ready. `issue_pld` is not required to be stable.
- **Flush.** A cycle with `flush=1` clears all valid bits at the next edge. Enqueue in that cycle is dropped, and issue in that cycle still occurs on the output (the ALU consumes it; squashing it is downstream's responsibility). From the next cycle, `count=0` and `issue_vld=0`.
- **Reset.**
  - All valid bits are 0 and `count=0`.
  - `issue_vld=0`, `issue_pld=0`, `enq_rdy=1`.
  - Reset asserted mid-operation discards all entries immediately (asynchronously).

## Timing

- **Enqueue to issue.** An entry enqueued with both operands ready, or captured at enqueue, asserts `issue_vld` in the cycle after enqueue. There is no enqueue-to-issue bypass.
- **Wakeup to issue.** A broadcast in cycle N makes the entry eligible in cycle N+1.
- **Back-to-back.** One issue per cycle is sustained when ready entries exist.
- **Full queue.** `enq_rdy` is low at `count==DEPTH` even if an issue fires that cycle. It rises the cycle after the issue.
- **Critical path.** The combinational path is the select priority mux plus payload mux to `issue_pld`. There are no combinational paths from `enq_*`/`wb_*` to `issue_*`.

## Structure

- **`toy_pack` additions:**
  - `iq_entry_t` struct: vld, `eu_pkg`, two tags, two rdy bits.
  - `ALU_IQ_DEPTH` and `WB_PORTS` constants.
- **Sub-module `toy_alu_iq_entry`.** One instance per slot. It holds:
  - the wakeup tag compare and capture muxing;
  - the next-state select among hold, shift-in from slot+1, and enqueue write.
- **Top-level logic:** count, priority select, and shift/enqueue control.

## Test plan

- **Ready-at-enqueue.** Empty queue; enqueue ADDI with rs1 rdy, value `0x5`, imm `3`. Expect `issue_vld=1` next cycle, `issue_pld.reg_rs1_val=0x5`, `count` back to 0 after `issue_rdy=1`.
- **Wakeup capture.** Enqueue entry A with `rs2_idx=17`, not ready. Two cycles later drive `wb_vld[1]=1`, `wb_idx[1]=17`, `wb_data[1]=0xDEAD_BEEF`. Expect `issue_vld=1` exactly one cycle later, with `reg_rs2_val=0xDEADBEEF`.
- **Age order.** Enqueue A (waits on tag 9), then B and C (both ready). Expect issue order B, C. Broadcast tag 9; expect A issues next.
- **Full and simultaneous events.** Fill 8 entries; expect `enq_rdy=0`. Issue one while holding `enq_vld`. Expect `enq_rdy=1` the following cycle and an accepted enqueue landing in slot 7.
- **Enqueue/wakeup collision.** Enqueue with `rs1_idx=4` not ready while `wb_vld[0]=1`, `wb_idx[0]=4`, `wb_data=0x77`. Expect issue next cycle with `rs1=0x77`. Repeat with both ports matching tag 4; expect port 0's data.
- **Flush and reset.** With 5 entries, assert `flush` alongside an enqueue. Expect `count=0` next cycle and the new entry dropped. Then assert `rst_n=0` mid-stream; expect `issue_vld=0` immediately and `count=0`.
